// File: rtl/vrf_read_arbiter.sv
// Per-lane VRF read arbiter: per-bank round-robin grant of operand reads plus fixed-latency return routing.
// Define ARA_VRF_ARB_PRIO_EN to let requesters in HpMask beat all others, with a separate RR pointer per class.
module vrf_read_arbiter #(
  parameter int unsigned      NrReq      = 9,
  parameter int unsigned      NrBanks    = 8,
  parameter int unsigned      VrfAddrW   = 12,
  parameter int unsigned      VrfLatency = 1,
  parameter logic [NrReq-1:0] HpMask     = 9'h180
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NrReq-1:0]                              req_i,
  input  logic [NrReq*VrfAddrW-1:0]                     addr_i,
  input  logic [NrReq-1:0]                              queue_ready_i,
  output logic [NrReq-1:0]                              gnt_o,
  output logic [NrBanks-1:0]                            bank_req_o,
  output logic [NrBanks*(VrfAddrW-$clog2(NrBanks))-1:0] bank_addr_o,
  input  logic [NrBanks*64-1:0]                         bank_rdata_i,
  output logic [NrReq-1:0]                              operand_issued_o,
  output logic [NrReq*64-1:0]                           operand_o,
  output logic [NrReq-1:0]                              operand_valid_o
);

  localparam int unsigned BankW = $clog2(NrBanks);
  localparam int unsigned WordW = VrfAddrW - BankW;
  localparam int unsigned IdW   = $clog2(NrReq);
  localparam int unsigned DataW = 64;

  // First requester at or after ptr (circularly) present in cand; MSB flags a hit.
  function automatic logic [IdW:0] rr_pick(input logic [NrReq-1:0] cand, input logic [IdW-1:0] ptr);
    logic           found;
    logic [IdW-1:0] idx;
    int unsigned    s;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NrReq; off++) begin
      s = 32'(ptr) + off;
      if (s >= NrReq) s = s - NrReq;
      if (!found && cand[IdW'(s)]) begin
        found = 1'b1;
        idx   = IdW'(s);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IdW-1:0] rr_next(input logic [IdW-1:0] w);
    return (w == IdW'(NrReq - 1)) ? '0 : w + IdW'(1);
  endfunction

  logic [NrReq-1:0] elig;
  logic [BankW-1:0] bank_of [NrReq];
  logic [WordW-1:0] word_of [NrReq];
  logic [NrReq-1:0] gnt_hot [NrBanks];
  logic [NrBanks-1:0] ret_v;
  logic [IdW-1:0]   ret_id  [NrBanks];

  // Reset suppresses all grants in the reset cycle.
  assign elig = req_i & queue_ready_i & {NrReq{~rst_i}};

  for (genvar r = 0; r < NrReq; r++) begin : g_req
    assign bank_of[r] = addr_i[r*VrfAddrW +: BankW];
    assign word_of[r] = addr_i[r*VrfAddrW + BankW +: WordW];
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    logic [NrReq-1:0]          cand;
    logic [IdW:0]              pick;
    logic [IdW-1:0]            win;
    logic [VrfLatency-1:0]     pv_q;
    logic [VrfLatency*IdW-1:0] pid_q;

    for (genvar r = 0; r < NrReq; r++) begin : g_cand
      assign cand[r] = elig[r] & (bank_of[r] == BankW'(b));
    end

`ifdef ARA_VRF_ARB_PRIO_EN
    logic [IdW-1:0] rr_hp_q, rr_hp_d, rr_lp_q, rr_lp_d;
    logic           hp_sel;

    // High-priority class wins whenever any of its members is eligible here.
    always_comb begin
      hp_sel  = |(cand & HpMask);
      rr_hp_d = rr_hp_q;
      rr_lp_d = rr_lp_q;
      pick    = hp_sel ? rr_pick(cand & HpMask, rr_hp_q) : rr_pick(cand & ~HpMask, rr_lp_q);
      if (pick[IdW]) begin
        if (hp_sel) rr_hp_d = rr_next(pick[IdW-1:0]);
        else        rr_lp_d = rr_next(pick[IdW-1:0]);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rr_hp_q <= '0;
        rr_lp_q <= '0;
      end else begin
        rr_hp_q <= rr_hp_d;
        rr_lp_q <= rr_lp_d;
      end
    end
`else
    logic [IdW-1:0] rr_q, rr_d;

    always_comb begin
      pick = rr_pick(cand, rr_q);
      rr_d = pick[IdW] ? rr_next(pick[IdW-1:0]) : rr_q;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) rr_q <= '0;
      else       rr_q <= rr_d;
    end
`endif

    assign win                         = pick[IdW-1:0];
    assign bank_req_o[b]               = pick[IdW];
    assign gnt_hot[b]                  = pick[IdW] ? (NrReq'(1) << win) : '0;
    assign bank_addr_o[b*WordW +: WordW] = pick[IdW] ? word_of[win] : '0;

    // Return pipeline: {valid, winner} shifts in at the low end, leaves at the top.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pv_q  <= '0;
        pid_q <= '0;
      end else begin
        pv_q  <= VrfLatency'({pv_q, pick[IdW]});
        pid_q <= (VrfLatency*IdW)'({pid_q, win});
      end
    end

    assign ret_v[b]  = pv_q[VrfLatency-1] & ~rst_i;
    assign ret_id[b] = pid_q[VrfLatency*IdW-1 -: IdW];
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NrBanks; b++) gnt_o = gnt_o | gnt_hot[b];
  end

  assign operand_issued_o = gnt_o;

  // Route each bank's read data to the requester it was granted to; idle lanes read zero.
  always_comb begin
    operand_valid_o = '0;
    operand_o       = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      if (ret_v[b]) begin
        operand_valid_o[ret_id[b]]              = 1'b1;
        operand_o[32'(ret_id[b])*DataW +: DataW] = bank_rdata_i[b*DataW +: DataW];
      end
    end
  end

endmodule
